level_sequencer: RTL and testbench
==================================

Name: level_sequencer

Overview:
- Top-level game controller for the symmetric-counter game.
- Sequences each level: load → play under a per-level countdown → request judgement → advance, lose or win.
- Drives the judge's levelComplete strobe and consumes its incLevel/lose result pulses.
- Provides level number, seconds remaining and game status to the display logic.

Parameters:
- MAX_LEVEL, 15: last level; passing it wins the game (1..15, fits 4 bits).
- TICKS_PER_SEC, 100000000: Clk100M cycles per countdown second (benches use 4).
- BASE_TIME, 20: seconds loaded at the start of every level (1..31).
- JUDGE_TIMEOUT, 8: cycles to wait for a judge result before forcing game over.

Ports:
- Clk100M  in  1  system clock, all logic on rising edge.
- Reset  in  1  asynchronous, active-high; clears everything to IDLE.
- start  in  1  single-cycle pulse (debounced button); starts or restarts the game.
- playerDone  in  1  single-cycle pulse; player declares the level finished.
- incLevel  in  1  judge result pulse: pass.
- lose  in  1  judge result pulse: fail.
- levelComplete  out  1  one-cycle strobe to the judge.
- loadLevel  out  1  one-cycle strobe; counter datapath reloads its pattern for the current level.
- level  out  4  current level, 1..MAX_LEVEL; 0 in IDLE.
- secondsLeft  out  5  countdown value.
- playing  out  1  high while in PLAY.
- gameOver  out  1  high while in OVER.
- win  out  1  high while in WON.

Behaviour:
- Reset (async): state=IDLE; level=0, secondsLeft=0, prescaler=0, timeout counter=0; all strobes and flags 0.
- All outputs are registered; strobes last exactly one cycle.
- IDLE:
  - start → LOAD with level=1.
  - playerDone, incLevel and lose are ignored.
- LOAD (1 cycle):
  - loadLevel=1.
  - secondsLeft=BASE_TIME, prescaler=0.
  - Next state: PLAY.
- PLAY:
  - playing=1.
  - Prescaler counts 0..TICKS_PER_SEC-1 and wraps; on the wrap cycle secondsLeft decrements.
  - If the tick takes secondsLeft from 1 to 0 → OVER.
  - playerDone → JUDGE. playerDone has priority over a simultaneous final tick: secondsLeft is frozen and the level is judged.
  - start is ignored.
- JUDGE (1 cycle):
  - levelComplete=1.
  - Timeout counter cleared.
  - Next state: WAIT.
- WAIT:
  - The timeout counter increments every cycle.
  - lose → OVER. lose has priority if it coincides with incLevel.
  - incLevel with level==MAX_LEVEL → WON.
  - incLevel with level<MAX_LEVEL → level+1, then LOAD.
  - No result within JUDGE_TIMEOUT cycles → OVER.
  - A result arriving in the same cycle the counter reaches JUDGE_TIMEOUT is honoured.
- OVER:
  - gameOver=1.
  - level and secondsLeft hold their last values for display.
  - start → LOAD with level=1.
- WON:
  - win=1; level holds at MAX_LEVEL.
  - start → LOAD with level=1.
- Widths and wrap:
  - level never exceeds MAX_LEVEL and never wraps.
  - secondsLeft never underflows.
  - The prescaler is wide enough for TICKS_PER_SEC-1.
- Stray pulses: incLevel/lose outside WAIT and playerDone outside PLAY are ignored.
- Reset mid-operation: immediate return to IDLE, no pending strobe is emitted; the game restarts only on a new start.

Test Plan (TICKS_PER_SEC=4, BASE_TIME=3, MAX_LEVEL=2, JUDGE_TIMEOUT=8):
- Reset, then start → one cycle later loadLevel=1 for 1 cycle, level=1, secondsLeft=3, playing=1; every 4 cycles secondsLeft counts 3→2→1→0, then gameOver=1 and playing=0.
- In PLAY, pulse playerDone → levelComplete high exactly 1 cycle; incLevel 2 cycles later → loadLevel pulse, level=2, secondsLeft=3.
- At level 2, playerDone, then incLevel → win=1, level=2; subsequent start → level=1 and loadLevel pulse.
- playerDone, then lose and incLevel asserted together in WAIT → gameOver=1, level unchanged.
- playerDone with no judge response → gameOver=1 after 8 WAIT cycles; playerDone coinciding with the 1→0 tick → JUDGE, not OVER.
- Assert Reset during WAIT and during PLAY → all outputs 0 on the same edge; start pulses and judge pulses arriving in IDLE are ignored until a start after Reset is released.

Source files
------------

// File: rtl/level_sequencer.sv
// level_sequencer: top-level game controller for the symmetric-counter game.
// Each level runs LOAD -> PLAY (per-level countdown) -> JUDGE -> WAIT, and then
// advances to the next level, ends the game (OVER) or wins it (WON).
//
// Ports
//   Clk100M        in   system clock, rising edge
//   Reset          in   asynchronous active-high reset, returns to IDLE
//   start          in   pulse: start / restart the game
//   playerDone     in   pulse: player declares the level finished (PLAY only)
//   incLevel       in   judge result pulse: pass (WAIT only)
//   lose           in   judge result pulse: fail (WAIT only, wins over incLevel)
//   levelComplete  out  one-cycle strobe to the judge
//   loadLevel      out  one-cycle strobe to reload the level pattern
//   level          out  current level 1..MAX_LEVEL, 0 in IDLE
//   secondsLeft    out  countdown value
//   playing        out  high in PLAY
//   gameOver       out  high in OVER
//   win            out  high in WON
module level_sequencer #(
  parameter int MAX_LEVEL     = 15,
  parameter int TICKS_PER_SEC = 100000000,
  parameter int BASE_TIME     = 20,
  parameter int JUDGE_TIMEOUT = 8
) (
  input  logic       Clk100M,
  input  logic       Reset,
  input  logic       start,
  input  logic       playerDone,
  input  logic       incLevel,
  input  logic       lose,
  output logic       levelComplete,
  output logic       loadLevel,
  output logic [3:0] level,
  output logic [4:0] secondsLeft,
  output logic       playing,
  output logic       gameOver,
  output logic       win
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int TW = $clog2(JUDGE_TIMEOUT + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(JUDGE_TIMEOUT - 1);
  localparam logic [4:0]    C_BASE     = 5'(BASE_TIME);
  localparam logic [3:0]    C_MAX      = 4'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PLAY, S_JUDGE, S_WAIT, S_OVER, S_WON
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [TW-1:0] r_tmo;
  logic          r_levelComplete;
  logic          r_loadLevel;
  logic [3:0]    r_level;
  logic [4:0]    r_secondsLeft;
  logic          r_playing;
  logic          r_gameOver;
  logic          r_win;

  // Flags are set on the transition into their state so every output is a
  // plain register that matches the state it describes.
  always_ff @(posedge Clk100M or posedge Reset) begin
    if (Reset) begin
      r_state         <= S_IDLE;
      r_presc         <= '0;
      r_tmo           <= '0;
      r_levelComplete <= 1'b0;
      r_loadLevel     <= 1'b0;
      r_level         <= '0;
      r_secondsLeft   <= '0;
      r_playing       <= 1'b0;
      r_gameOver      <= 1'b0;
      r_win           <= 1'b0;
    end else begin
      r_levelComplete <= 1'b0;
      r_loadLevel     <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER, S_WON: begin
          if (start) begin
            r_state       <= S_LOAD;
            r_level       <= 4'd1;
            r_loadLevel   <= 1'b1;
            r_secondsLeft <= C_BASE;
            r_presc       <= '0;
            r_gameOver    <= 1'b0;
            r_win         <= 1'b0;
          end
        end
        S_LOAD: begin
          r_state   <= S_PLAY;
          r_playing <= 1'b1;
        end
        S_PLAY: begin
          // playerDone beats a coinciding final tick: the time is frozen.
          if (playerDone) begin
            r_state         <= S_JUDGE;
            r_playing       <= 1'b0;
            r_levelComplete <= 1'b1;
          end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
            if (r_secondsLeft != 5'd0)
              r_secondsLeft <= r_secondsLeft - 5'd1;
            if (r_secondsLeft <= 5'd1) begin
              r_state    <= S_OVER;
              r_playing  <= 1'b0;
              r_gameOver <= 1'b1;
            end
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
        S_JUDGE: begin
          r_state <= S_WAIT;
          r_tmo   <= '0;
        end
        S_WAIT: begin
          r_tmo <= r_tmo + TW'(1);
          // A result on the last allowed cycle is still honoured because
          // results are tested before the timeout.
          if (lose) begin
            r_state    <= S_OVER;
            r_gameOver <= 1'b1;
          end else if (incLevel) begin
            if (r_level >= C_MAX) begin
              r_state <= S_WON;
              r_win   <= 1'b1;
            end else begin
              r_state       <= S_LOAD;
              r_level       <= r_level + 4'd1;
              r_loadLevel   <= 1'b1;
              r_secondsLeft <= C_BASE;
              r_presc       <= '0;
            end
          end else if (r_tmo == TMO_LAST) begin
            r_state    <= S_OVER;
            r_gameOver <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign levelComplete = r_levelComplete;
  assign loadLevel     = r_loadLevel;
  assign level         = r_level;
  assign secondsLeft   = r_secondsLeft;
  assign playing       = r_playing;
  assign gameOver      = r_gameOver;
  assign win           = r_win;

endmodule

// File: tb/tb_level_sequencer.sv
module tb_level_sequencer;
  localparam int T  = 4;
  localparam int B  = 3;
  localparam int ML = 2;
  localparam int JT = 8;

  logic       Clk100M = 1'b0;
  logic       Reset, start, playerDone, incLevel, lose;
  logic       levelComplete, loadLevel, playing, gameOver, win;
  logic [3:0] level;
  logic [4:0] secondsLeft;

  int checks = 0;
  int errors = 0;
  int m_level;   // model: current level
  int m_sec;     // model: seconds shown

  always #5 Clk100M = ~Clk100M;

  level_sequencer #(.MAX_LEVEL(ML), .TICKS_PER_SEC(T), .BASE_TIME(B), .JUDGE_TIMEOUT(JT)) dut (
    .Clk100M(Clk100M), .Reset(Reset), .start(start), .playerDone(playerDone),
    .incLevel(incLevel), .lose(lose), .levelComplete(levelComplete), .loadLevel(loadLevel),
    .level(level), .secondsLeft(secondsLeft), .playing(playing), .gameOver(gameOver), .win(win)
  );

  // Observed outputs as {levelComplete, loadLevel, level, secondsLeft, playing, gameOver, win}
  wire [13:0] w_obs = {levelComplete, loadLevel, level, secondsLeft, playing, gameOver, win};

  function automatic logic [13:0] ev(input logic lc, input logic ll, input int lv, input int s,
                                     input logic p, input logic g, input logic w);
    return {lc, ll, 4'(lv), 5'(s), p, g, w};
  endfunction

  // One clock cycle with the given input pulses; returns #1 after the edge.
  task automatic step(input logic s, input logic pd, input logic il, input logic lo);
    start = s; playerDone = pd; incLevel = il; lose = lo;
    @(posedge Clk100M);
    #1;
    start = 0; playerDone = 0; incLevel = 0; lose = 0;
  endtask

  // Plays one level that has just been loaded. j = PLAY cycle of playerDone
  // (>= B*T means never), w = WAIT cycle of the judge result, res: 0 none,
  // 1 incLevel, 2 lose, 3 both. outcome: 0 over, 1 next level loaded, 2 won.
  task automatic run_level(input int j, input int w, input int res, input string tag,
                           output int outcome);
    logic [13:0] exp;
    logic il, lo;
    checks++;
    exp = ev(0, 1, m_level, B, 0, 0, 0);
    if (w_obs !== exp) begin
      errors++; $display("FAIL %s load: got %h expected %h", tag, w_obs, exp);
    end
    step(0, 0, 0, 0);
    m_sec = B;
    checks++;
    exp = ev(0, 0, m_level, B, 1, 0, 0);
    if (w_obs !== exp) begin
      errors++; $display("FAIL %s play_entry: got %h expected %h", tag, w_obs, exp);
    end
    for (int i = 0; i < B * T; i++) begin
      // start, incLevel and lose are all stray here and must be ignored
      step(1'($urandom_range(0, 1)), i == j, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (i == j) begin
        m_sec = B - i / T;
        exp = ev(1, 0, m_level, m_sec, 0, 0, 0);
      end else begin
        m_sec = B - (i + 1) / T;
        exp = (i + 1 == B * T) ? ev(0, 0, m_level, 0, 0, 1, 0) : ev(0, 0, m_level, m_sec, 1, 0, 0);
      end
      checks++;
      if (w_obs !== exp) begin
        errors++; $display("FAIL %s play[%0d]: got %h expected %h", tag, i, w_obs, exp);
      end
      if (i == j) break;
      if (i + 1 == B * T) begin
        outcome = 0;
        return;
      end
    end
    step(0, 1, 0, 0);  // stray playerDone during JUDGE
    checks++;
    exp = ev(0, 0, m_level, m_sec, 0, 0, 0);
    if (w_obs !== exp) begin
      errors++; $display("FAIL %s judge_strobe_len: got %h expected %h", tag, w_obs, exp);
    end
    for (int c = 0; c < JT; c++) begin
      il = (res != 0) && (c == w) && res[0];
      lo = (res != 0) && (c == w) && res[1];
      step(0, 0, il, lo);
      if (lo) begin
        exp = ev(0, 0, m_level, m_sec, 0, 1, 0); outcome = 0;
      end else if (il && m_level == ML) begin
        exp = ev(0, 0, m_level, m_sec, 0, 0, 1); outcome = 2;
      end else if (il) begin
        m_level++; exp = ev(0, 1, m_level, B, 0, 0, 0); outcome = 1;
      end else if (c == JT - 1) begin
        exp = ev(0, 0, m_level, m_sec, 0, 1, 0); outcome = 0;
      end else begin
        exp = ev(0, 0, m_level, m_sec, 0, 0, 0); outcome = -1;
      end
      checks++;
      if (w_obs !== exp) begin
        errors++; $display("FAIL %s wait[%0d]: got %h expected %h", tag, c, w_obs, exp);
      end
      if (outcome >= 0) return;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (w_obs !== 14'd0) begin
      errors++; $display("FAIL reset_state: got %h expected %h", w_obs, 14'd0);
    end
    @(negedge Clk100M);
    Reset = 0;
    step(0, 1, 1, 1);
    checks++;
    if (w_obs !== 14'd0) begin
      errors++; $display("FAIL idle_ignores_pulses: got %h expected %h", w_obs, 14'd0);
    end
  endtask

  task automatic test_countdown;
    int o;
    step(1, 0, 0, 0); m_level = 1;
    run_level(B * T, 0, 0, "countdown", o);
    step(0, 1, 1, 1);
    checks++;
    if (w_obs !== ev(0, 0, 1, 0, 0, 1, 0)) begin
      errors++; $display("FAIL over_hold: got %h expected %h", w_obs, ev(0, 0, 1, 0, 0, 1, 0));
    end
  endtask

  task automatic test_pass_and_win;
    int o;
    step(1, 0, 0, 0); m_level = 1;
    run_level(2, 1, 1, "pass_l1", o);
    run_level(5, 0, 1, "win_l2", o);
    step(0, 0, 1, 1);
    checks++;
    if (w_obs !== ev(0, 0, ML, m_sec, 0, 0, 1)) begin
      errors++; $display("FAIL won_hold: got %h expected %h", w_obs, ev(0, 0, ML, m_sec, 0, 0, 1));
    end
    step(1, 0, 0, 0);
    checks++;
    if (w_obs !== ev(0, 1, 1, B, 0, 0, 0)) begin
      errors++; $display("FAIL restart_after_win: got %h expected %h", w_obs, ev(0, 1, 1, B, 0, 0, 0));
    end
  endtask

  task automatic test_lose_priority;
    int o;
    m_level = 1;  // already loaded by the restart above
    run_level(1, 3, 3, "lose_priority", o);
  endtask

  task automatic test_judge_timeout;
    int o;
    step(1, 0, 0, 0); m_level = 1;
    run_level(0, JT, 1, "timeout", o);        // result too late, never sent
    step(1, 0, 0, 0); m_level = 1;
    run_level(0, JT - 1, 1, "last_cycle", o);  // honoured on the final cycle
    run_level(B * T - 1, 0, 2, "final_tick", o);
  endtask

  task automatic test_reset_mid;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);  // now in WAIT
    #2 Reset = 1;
    #1;
    checks++;
    if (w_obs !== 14'd0) begin
      errors++; $display("FAIL reset_in_wait: got %h expected %h", w_obs, 14'd0);
    end
    @(negedge Clk100M);
    step(1, 0, 1, 0);
    checks++;
    if (w_obs !== 14'd0) begin
      errors++; $display("FAIL start_during_reset: got %h expected %h", w_obs, 14'd0);
    end
    @(negedge Clk100M);
    Reset = 0;
    step(0, 0, 1, 1);
    checks++;
    if (w_obs !== 14'd0) begin
      errors++; $display("FAIL idle_after_reset: got %h expected %h", w_obs, 14'd0);
    end
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);  // in PLAY
    #2 Reset = 1;
    #1;
    checks++;
    if (w_obs !== 14'd0) begin
      errors++; $display("FAIL reset_in_play: got %h expected %h", w_obs, 14'd0);
    end
    @(negedge Clk100M);
    Reset = 0;
    step(0, 1, 0, 0);
    checks++;
    if (w_obs !== 14'd0) begin
      errors++; $display("FAIL play_after_reset: got %h expected %h", w_obs, 14'd0);
    end
    step(1, 0, 0, 0);
    checks++;
    if (w_obs !== ev(0, 1, 1, B, 0, 0, 0)) begin
      errors++; $display("FAIL start_after_reset: got %h expected %h", w_obs, ev(0, 1, 1, B, 0, 0, 0));
    end
  endtask

  task automatic test_random;
    int o;
    logic [13:0] exp;
    m_level = 1;  // loaded by the last start above
    for (int g = 0; g < 12; g++) begin
      if (g != 0) begin
        step(1, 0, 0, 0);
        m_level = 1;
      end
      o = 1;
      while (o == 1)
        run_level($urandom_range(0, B * T), $urandom_range(0, JT + 1), $urandom_range(0, 3), "random", o);
      step(0, 1, 1, 1);
      exp = (o == 2) ? ev(0, 0, ML, m_sec, 0, 0, 1) : ev(0, 0, m_level, m_sec, 0, 1, 0);
      checks++;
      if (w_obs !== exp) begin
        errors++; $display("FAIL random_end[%0d]: got %h expected %h", g, w_obs, exp);
      end
    end
  endtask

  initial begin
    Reset = 1; start = 0; playerDone = 0; incLevel = 0; lose = 0;
    m_level = 0; m_sec = 0;
    repeat (2) @(posedge Clk100M);
    #1;
    test_reset();
    test_countdown();
    test_pass_and_win();
    test_lose_priority();
    test_judge_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
